pe_feeder: RTL and testbench
============================

# pe_feeder

Operand feeder directly upstream of the processing element. It loads one filter row and one ifmap row into local scratchpads over valid/ready handshakes. It then streams every (ifmap, filter) pair of a 1-D sliding-window convolution into the PE's `input_ifmap`/`input_filter`/`en` inputs, one pair per cycle, and marks window boundaries so a downstream accumulator can close each output psum.

## Interface
- `DATA_W`, 16, operand width (matches PE operand width)
- `FILT_LEN`, 3, filter taps K per window (≥1)
- `IFMAP_MAX`, 16, ifmap scratchpad depth; max row width W
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `start` input 1 — begin job; sampled only in IDLE
- `cfg_width` input $clog2(IFMAP_MAX+1) — row width W, latched at start
- `filt_valid` / `filt_ready` input/output 1 — filter word handshake
- `filt_data` input DATA_W — filter tap, tap 0 first
- `ifmap_valid` / `ifmap_ready` input/output 1 — ifmap word handshake
- `ifmap_data` input DATA_W — ifmap element, element 0 first
- `hold` input 1 — downstream stall; freezes issue
- `busy` output 1 — high outside IDLE
- `done` output 1 — one-cycle job-complete pulse
- `pe_ifmap`, `pe_filter` output DATA_W — registered operands to the PE
- `pe_en` output 1 — operand pair valid this cycle
- `pe_last` output 1 — pair is tap K-1 of its window
- `pe_win` output $clog2(IFMAP_MAX) — output window index o of current pair

## Operation
- Five-state FSM:
  - IDLE → LOAD_FILT on `start`.
  - LOAD_FILT → LOAD_IFMAP after K accepted words.
  - LOAD_IFMAP → RUN after W accepted words.
  - RUN → DONE after the final pair.
  - DONE → IDLE unconditionally.
- Latching: W = min(`cfg_width`, IFMAP_MAX), latched on the start edge. `start` outside IDLE is ignored.
- LOAD_FILT: `filt_ready`=1. Each `filt_valid`&&`filt_ready` edge writes `filt_data` to filt[ptr] and increments ptr. `ifmap_ready`=0.
- LOAD_IFMAP: `ifmap_ready`=1, same write/increment rule into ifmap[]. If W=0, this state is skipped and the FSM goes straight to DONE.
- RUN: windows o = 0..W-K, taps k = 0..K-1, k innermost. On each edge with `hold`=0, register:
  - `pe_ifmap` ← ifmap[o+k]
  - `pe_filter` ← filt[k]
  - `pe_en` ← 1
  - `pe_last` ← (k==K-1)
  - `pe_win` ← o
  - then advance k, wrapping to 0 and incrementing o.
- Hold: on an edge with `hold`=1, `pe_en` ← 0 and the counters and operand registers keep their values. No pair is lost or repeated.
- Issue count: total `pe_en` beats = (W-K+1)·K. If W < K there are zero beats and RUN goes directly to DONE.
- Widths: operands pass through unmodified. No arithmetic is performed on data.

## Timing
- Reset (async, `rst_n`=0): state IDLE, all pointers and counters 0, `busy`/`done`/`pe_en`/`pe_last`/`filt_ready`/`ifmap_ready` = 0, `pe_ifmap`/`pe_filter`/`pe_win` = 0. Scratchpad contents are don't-care.
- Reset mid-job: the job is abandoned immediately. After release, the block waits for a new `start`.
- `busy` rises the cycle after the start edge.
- `filt_ready` is high from the first LOAD_FILT cycle. Handshake words are accepted back-to-back at one per cycle.
- The first `pe_en` beat is visible the cycle after the RUN-entry cycle, i.e. 2 cycles after the edge accepting the last ifmap word.
- Without `hold`, the beats are contiguous.
- `done` is high for exactly one cycle: the cycle after the final `pe_en` beat (state DONE). `pe_en` is 0 in that cycle.
- `busy` falls with the return to IDLE. A `start` in the DONE cycle is ignored.
- `hold` acts on the edge only. A held RUN cycle shows `pe_en`=0 on the following cycle.

## Configuration
- `FEEDER_FILT_REUSE_EN` defined: adds input `keep_filt` (1 bit, sampled with `start`) and an internal `filt_loaded` flag.
  - `filt_loaded` is set when LOAD_FILT completes and cleared by reset.
  - If `keep_filt`=1 and `filt_loaded`=1 at start, IDLE goes → LOAD_IFMAP directly and the stored filter is reused.
- `FEEDER_FILT_REUSE_EN` undefined: the port and flag do not exist, and every job loads the filter.

## Test plan
- K=3, W=5, filter {1,2,3}, ifmap {1,2,3,4,5}, no hold → 9 beats with pairs (1,1)(2,2)(3,3)(2,1)(3,2)(4,3)(3,1)(4,2)(5,3). `pe_last` is set on beats 3, 6 and 9. `pe_win` = 0,0,0,1,1,1,2,2,2. `done` is high 1 cycle after beat 9. Accumulated window sums are 14, 20, 26.
- Same job with `hold` high for 2 cycles after beat 4 → `pe_en` is low for 2 cycles, then beats 5–9 resume with identical values. The total is still 9 beats.
- Random `filt_valid`/`ifmap_valid` gaps → scratchpad contents and beat sequence are unchanged. The ready signals are never high outside their load states.
- W=2 (< K=3) → the filter and 2 ifmap words are accepted, zero `pe_en` beats occur, and `done` pulses once. With W=0 → no ifmap words are accepted.
- `rst_n` pulled low during beat 5 → all outputs are 0 immediately and the block stays IDLE until a new `start`. A subsequent full job matches the first scenario.
- With `FEEDER_FILT_REUSE_EN`: second job with `keep_filt`=1 and ifmap {5,4,3,2,1} → `filt_ready` never asserts, and window sums are 22, 16, 10.

Source files
------------

// File: rtl/pe_feeder.sv
// rtl/pe_feeder.sv - operand feeder that streams 1-D sliding-window pairs into the PE
//
// Loads one filter row (K taps) and one ifmap row (W elements) into local
// scratchpads over valid/ready handshakes, then issues every (ifmap, filter)
// pair of the sliding-window convolution, one pair per cycle, k innermost.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, cfg_width            begin job (IDLE only); row width W, clamped to IFMAP_MAX
//   keep_filt                   reuse the stored filter (FEEDER_FILT_REUSE_EN builds only)
//   filt_valid/ready/data       filter tap stream, tap 0 first
//   ifmap_valid/ready/data      ifmap element stream, element 0 first
//   hold                        downstream stall, freezes issue on the edge it is seen
//   busy, done                  job in progress; one-cycle completion pulse
//   pe_ifmap, pe_filter, pe_en  registered operand pair and its valid
//   pe_last, pe_win             pair closes its window; window index of the pair
//
// Build option: define FEEDER_FILT_REUSE_EN to add keep_filt and filter reuse.
module pe_feeder #(
  parameter int DATA_W    = 16,
  parameter int FILT_LEN  = 3,
  parameter int IFMAP_MAX = 16,
  localparam int CW  = $clog2(IFMAP_MAX + 1),
  localparam int IAW = (IFMAP_MAX > 1) ? $clog2(IFMAP_MAX) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef FEEDER_FILT_REUSE_EN
  input  logic              keep_filt,
`endif
  input  logic [CW-1:0]     cfg_width,
  input  logic              filt_valid,
  output logic              filt_ready,
  input  logic [DATA_W-1:0] filt_data,
  input  logic              ifmap_valid,
  output logic              ifmap_ready,
  input  logic [DATA_W-1:0] ifmap_data,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] pe_ifmap,
  output logic [DATA_W-1:0] pe_filter,
  output logic              pe_en,
  output logic              pe_last,
  output logic [IAW-1:0]    pe_win
);

  localparam int FAW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int KXW = CW + 1;
  // K clamped so that it still compares correctly against any W when K > IFMAP_MAX
  localparam logic [KXW-1:0] K_X    = KXW'((FILT_LEN > IFMAP_MAX) ? IFMAP_MAX + 1 : FILT_LEN);
  localparam logic [CW-1:0]  W_MAX  = CW'(IFMAP_MAX);
  localparam logic [FAW-1:0] K_LAST = FAW'(FILT_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_FILT,
    S_LOAD_IFMAP,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] filt_mem  [0:(1<<FAW)-1];
  logic [DATA_W-1:0] ifmap_mem [0:(1<<IAW)-1];
  logic [CW-1:0]     w_lat;
  logic [FAW-1:0]    fptr;
  logic [FAW-1:0]    k_cnt;
  logic [IAW-1:0]    iptr;
  logic [IAW-1:0]    o_cnt;
  logic              run_end;   // final pair already issued (or none to issue)
  logic [CW-1:0]     w_in;
  logic [IAW-1:0]    x_addr;
  logic              last_win;
  logic              reuse_filt;

  assign w_in     = (cfg_width > W_MAX) ? W_MAX : cfg_width;
  assign x_addr   = o_cnt + IAW'(k_cnt);
  // Only meaningful when W >= K, which is the only case RUN issues pairs
  assign last_win = (CW'(o_cnt) == (w_lat - K_X[CW-1:0]));

`ifdef FEEDER_FILT_REUSE_EN
  logic filt_loaded;
  assign reuse_filt = keep_filt && filt_loaded;
`else
  assign reuse_filt = 1'b0;
`endif

  // Scratchpads carry no reset; the ready flags gate every write
  always_ff @(posedge clk) begin
    if (filt_valid && filt_ready) begin
      filt_mem[fptr] <= filt_data;
    end
    if (ifmap_valid && ifmap_ready) begin
      ifmap_mem[iptr] <= ifmap_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      w_lat       <= '0;
      fptr        <= '0;
      iptr        <= '0;
      k_cnt       <= '0;
      o_cnt       <= '0;
      run_end     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      filt_ready  <= 1'b0;
      ifmap_ready <= 1'b0;
      pe_en       <= 1'b0;
      pe_last     <= 1'b0;
      pe_ifmap    <= '0;
      pe_filter   <= '0;
      pe_win      <= '0;
`ifdef FEEDER_FILT_REUSE_EN
      filt_loaded <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            w_lat   <= w_in;
            busy    <= 1'b1;
            fptr    <= '0;
            iptr    <= '0;
            k_cnt   <= '0;
            o_cnt   <= '0;
            run_end <= 1'b0;
            if (!reuse_filt) begin
              state      <= S_LOAD_FILT;
              filt_ready <= 1'b1;
            end else if (w_in == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state       <= S_LOAD_IFMAP;
              ifmap_ready <= 1'b1;
            end
          end
        end

        S_LOAD_FILT: begin
          if (filt_valid && filt_ready) begin
            fptr <= fptr + FAW'(1);
            if (fptr == K_LAST) begin
              fptr       <= '0;
              filt_ready <= 1'b0;
`ifdef FEEDER_FILT_REUSE_EN
              filt_loaded <= 1'b1;
`endif
              // An empty row has nothing to load or issue
              if (w_lat == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state       <= S_LOAD_IFMAP;
                ifmap_ready <= 1'b1;
              end
            end
          end
        end

        S_LOAD_IFMAP: begin
          if (ifmap_valid && ifmap_ready) begin
            iptr <= iptr + IAW'(1);
            if (CW'(iptr) == (w_lat - CW'(1))) begin
              iptr        <= '0;
              ifmap_ready <= 1'b0;
              state       <= S_RUN;
              // A row narrower than the filter yields no windows at all
              run_end     <= ({1'b0, w_lat} < K_X);
            end
          end
        end

        S_RUN: begin
          if (run_end) begin
            // Leave one cycle after the last beat so done never overlaps pe_en
            pe_en   <= 1'b0;
            pe_last <= 1'b0;
            state   <= S_DONE;
            done    <= 1'b1;
          end else if (hold) begin
            pe_en <= 1'b0;
          end else begin
            pe_en     <= 1'b1;
            pe_ifmap  <= ifmap_mem[x_addr];
            pe_filter <= filt_mem[k_cnt];
            pe_last   <= (k_cnt == K_LAST);
            pe_win    <= o_cnt;
            if (k_cnt == K_LAST) begin
              k_cnt <= '0;
              o_cnt <= o_cnt + IAW'(1);
              if (last_win) begin
                run_end <= 1'b1;
              end
            end else begin
              k_cnt <= k_cnt + FAW'(1);
            end
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// tb/tb_pe_feeder.sv - self-checking bench for pe_feeder
`timescale 1ns/1ps
module tb_pe_feeder;

  localparam int DATA_W    = 16;
  localparam int FILT_LEN  = 3;
  localparam int IFMAP_MAX = 16;
  localparam int CW        = $clog2(IFMAP_MAX + 1);
  localparam int IAW       = $clog2(IFMAP_MAX);
  localparam int BUDGET    = 4000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              keep_filt = 1'b0;
  logic [CW-1:0]     cfg_width = '0;
  logic              filt_valid = 1'b0;
  logic              filt_ready;
  logic [DATA_W-1:0] filt_data = '0;
  logic              ifmap_valid = 1'b0;
  logic              ifmap_ready;
  logic [DATA_W-1:0] ifmap_data = '0;
  logic              hold = 1'b0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] pe_ifmap;
  logic [DATA_W-1:0] pe_filter;
  logic              pe_en;
  logic              pe_last;
  logic [IAW-1:0]    pe_win;

  always #5 clk = ~clk;

  pe_feeder #(.DATA_W(DATA_W), .FILT_LEN(FILT_LEN), .IFMAP_MAX(IFMAP_MAX)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
`ifdef FEEDER_FILT_REUSE_EN
    .keep_filt(keep_filt),
`endif
    .cfg_width(cfg_width),
    .filt_valid(filt_valid),
    .filt_ready(filt_ready),
    .filt_data(filt_data),
    .ifmap_valid(ifmap_valid),
    .ifmap_ready(ifmap_ready),
    .ifmap_data(ifmap_data),
    .hold(hold),
    .busy(busy),
    .done(done),
    .pe_ifmap(pe_ifmap),
    .pe_filter(pe_filter),
    .pe_en(pe_en),
    .pe_last(pe_last),
    .pe_win(pe_win)
  );

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] f;
    logic              last;
    logic [IAW-1:0]    win;
  } beat_t;

  typedef struct {
    int cfg;
    int f[FILT_LEN];
    int xbase;
    int xstep;
    int gap;
    int hold_pct;
    int exp_beats;
    int nsum;
    int s0, s1, s2;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] jf [FILT_LEN];
  logic [DATA_W-1:0] jx [IFMAP_MAX];
  int jcfg, jgap, jhold, jhold_at, jhold_len, jabort_at;
  bit jkeep, jstart_in_done;

  beat_t got[$];
  beat_t exp_q[$];
  int    got_cyc[$];
  int    done_cnt;
  bit    filt_ready_seen, ifmap_ready_seen, ready_bad, aborted;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({busy, done, pe_en, pe_last, filt_ready, ifmap_ready, pe_win, pe_ifmap, pe_filter});
  endfunction

  // Reference: every window o in 0..W-K, taps k innermost
  task automatic build_model(input int w);
    exp_q.delete();
    for (int o = 0; o + FILT_LEN <= w; o++) begin
      for (int k = 0; k < FILT_LEN; k++) begin
        exp_q.push_back('{x: jx[o+k], f: jf[k], last: (k == FILT_LEN - 1), win: IAW'(o)});
      end
    end
  endtask

  // Runs one job starting at a falling edge; all sampling and driving on falling edges
  task automatic run_job();
    int fi, xi, w, cyc, hold_left;
    bit fin, hold_fired;
    got.delete();
    got_cyc.delete();
    done_cnt = 0;
    filt_ready_seen = 0;
    ifmap_ready_seen = 0;
    ready_bad = 0;
    aborted = 0;
    hold_left = 0;
    hold_fired = 0;
    w = (jcfg > IFMAP_MAX) ? IFMAP_MAX : jcfg;
    start = 1'b1;
    cfg_width = CW'(jcfg);
    keep_filt = jkeep;
    @(negedge clk);
    start = 1'b0;
    check(busy == 1'b1, "busy_rise", 64'(busy), 64'(1));
    fi = jkeep ? FILT_LEN : 0;
    xi = 0;
    cyc = 0;
    fin = 0;
    while (cyc < BUDGET) begin
      if (filt_ready) filt_ready_seen = 1;
      if (ifmap_ready) ifmap_ready_seen = 1;
      if (fi >= FILT_LEN && filt_ready) ready_bad = 1;
      if ((fi < FILT_LEN || xi >= w) && ifmap_ready) ready_bad = 1;
      if (pe_en) begin
        got.push_back('{x: pe_ifmap, f: pe_filter, last: pe_last, win: pe_win});
        got_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        check(pe_en == 1'b0, "done_without_en", 64'(pe_en), 64'(0));
        fin = 1;
        break;
      end
      if (jabort_at > 0 && got.size() == jabort_at) begin
        rst_n = 1'b0;
        #1;
        check(out_vec() == 64'(0), "async_reset_outputs", out_vec(), 64'(0));
        aborted = 1;
        fin = 1;
        break;
      end
      if (jhold_at > 0 && !hold_fired && pe_en && got.size() == jhold_at) begin
        hold_left = jhold_len;
        hold_fired = 1;
      end
      filt_valid = (fi < FILT_LEN) && ($urandom_range(0, 99) >= jgap);
      filt_data = (fi < FILT_LEN) ? jf[fi] : '0;
      if (filt_valid && filt_ready) fi++;
      ifmap_valid = (xi < w) && ($urandom_range(0, 99) >= jgap);
      ifmap_data = (xi < w) ? jx[xi] : '0;
      if (ifmap_valid && ifmap_ready) xi++;
      if (hold_left > 0) begin
        hold = 1'b1;
        hold_left--;
      end else begin
        hold = ($urandom_range(0, 99) < jhold);
      end
      @(negedge clk);
      cyc++;
    end
    filt_valid = 1'b0;
    ifmap_valid = 1'b0;
    hold = 1'b0;
    check(fin, "job_timeout", 64'(cyc), 64'(BUDGET));
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check(out_vec() == 64'(0), "idle_after_reset", out_vec(), 64'(0));
    end else if (fin) begin
      start = jstart_in_done;
      @(negedge clk);
      start = 1'b0;
      check(busy == 1'b0 && done == 1'b0, "busy_fall_done_pulse", 64'({busy, done}), 64'(0));
      @(negedge clk);
      check(busy == 1'b0, "start_in_done_ignored", 64'(busy), 64'(0));
    end
  endtask

  task automatic compare_job(input string tag, input int exp_beats, input int nsum,
                             input int s0, input int s1, input int s2);
    int sums[$];
    int acc, n, w, req;
    w = (jcfg > IFMAP_MAX) ? IFMAP_MAX : jcfg;
    build_model(w);
    check(got.size() == exp_beats, {tag, "_beats"}, 64'(got.size()), 64'(exp_beats));
    check(done_cnt == 1, {tag, "_done_count"}, 64'(done_cnt), 64'(1));
    check(!ready_bad, {tag, "_ready_outside_load"}, 64'(ready_bad), 64'(0));
    if (w == 0) check(!ifmap_ready_seen, {tag, "_w0_no_ifmap_ready"}, 64'(ifmap_ready_seen), 64'(0));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check(got[i] == exp_q[i], $sformatf("%s_beat%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
    end
    acc = 0;
    foreach (got[i]) begin
      acc += int'(got[i].x) * int'(got[i].f);
      if (got[i].last) begin
        sums.push_back(acc);
        acc = 0;
      end
    end
    for (int j = 0; j < nsum; j++) begin
      req = (j == 0) ? s0 : (j == 1) ? s1 : s2;
      check(j < sums.size() && sums[j] == req, $sformatf("%s_sum%0d", tag, j),
            64'((j < sums.size()) ? sums[j] : -1), 64'(req));
    end
  endtask

  task automatic load_vec(input vec_t v);
    jcfg = v.cfg;
    for (int k = 0; k < FILT_LEN; k++) jf[k] = DATA_W'(v.f[k]);
    for (int i = 0; i < IFMAP_MAX; i++) jx[i] = DATA_W'(v.xbase + i * v.xstep);
    jgap = v.gap;
    jhold = v.hold_pct;
    jhold_at = 0;
    jhold_len = 0;
    jabort_at = 0;
    jkeep = 0;
    jstart_in_done = 0;
  endtask

  vec_t vecs[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: actual time limit reached required job completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap_chk, span_chk, w;
    vecs[0] = '{cfg: 5,  f: '{1, 2, 3}, xbase: 1, xstep: 1,  gap: 0,  hold_pct: 0,  exp_beats: 9,  nsum: 3, s0: 14, s1: 20, s2: 26};
    vecs[1] = '{cfg: 5,  f: '{1, 2, 3}, xbase: 1, xstep: 1,  gap: 40, hold_pct: 30, exp_beats: 9,  nsum: 3, s0: 14, s1: 20, s2: 26};
    vecs[2] = '{cfg: 2,  f: '{1, 2, 3}, xbase: 1, xstep: 1,  gap: 20, hold_pct: 0,  exp_beats: 0,  nsum: 0, s0: 0,  s1: 0,  s2: 0};
    vecs[3] = '{cfg: 0,  f: '{4, 5, 6}, xbase: 1, xstep: 1,  gap: 0,  hold_pct: 0,  exp_beats: 0,  nsum: 0, s0: 0,  s1: 0,  s2: 0};
    vecs[4] = '{cfg: 3,  f: '{1, 1, 1}, xbase: 7, xstep: 1,  gap: 0,  hold_pct: 20, exp_beats: 3,  nsum: 1, s0: 24, s1: 0,  s2: 0};
    vecs[5] = '{cfg: 20, f: '{1, 0, 0}, xbase: 1, xstep: 1,  gap: 10, hold_pct: 10, exp_beats: 42, nsum: 3, s0: 1,  s1: 2,  s2: 3};
    vecs[6] = '{cfg: 16, f: '{2, 0, 1}, xbase: 1, xstep: 1,  gap: 20, hold_pct: 0,  exp_beats: 42, nsum: 3, s0: 5,  s1: 8,  s2: 11};

    @(negedge clk);
    check(out_vec() == 64'(0), "reset_state", out_vec(), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      load_vec(vecs[r]);
      jstart_in_done = (r == 0);
      run_job();
      compare_job($sformatf("vec%0d", r), vecs[r].exp_beats, vecs[r].nsum, vecs[r].s0, vecs[r].s1, vecs[r].s2);
    end

    // Hold for two edges right after beat 4: a two-cycle hole, nothing lost or repeated
    load_vec(vecs[0]);
    jhold_at = 4;
    jhold_len = 2;
    run_job();
    compare_job("hold2", 9, 3, 14, 20, 26);
    gap_chk  = (got_cyc.size() >= 9) ? got_cyc[4] - got_cyc[3] : -1;
    span_chk = (got_cyc.size() >= 9) ? got_cyc[8] - got_cyc[0] : -1;
    check(gap_chk == 3, "hold2_gap", 64'(gap_chk), 64'(3));
    check(span_chk == 10, "hold2_span", 64'(span_chk), 64'(10));

    // Reset during beat 5, then a clean rerun of the basic job
    load_vec(vecs[0]);
    jabort_at = 5;
    run_job();
    check(aborted, "abort_reached", 64'(aborted), 64'(1));
    load_vec(vecs[0]);
    run_job();
    compare_job("after_reset", 9, 3, 14, 20, 26);
    span_chk = (got_cyc.size() >= 9) ? got_cyc[8] - got_cyc[0] : -1;
    check(span_chk == 8, "contiguous_beats", 64'(span_chk), 64'(8));

`ifdef FEEDER_FILT_REUSE_EN
    load_vec(vecs[0]);
    for (int i = 0; i < IFMAP_MAX; i++) jx[i] = DATA_W'(5 - i);
    jkeep = 1;
    run_job();
    compare_job("reuse", 9, 3, 22, 16, 10);
    check(!filt_ready_seen, "reuse_no_filt_ready", 64'(filt_ready_seen), 64'(0));
`endif

    for (int r = 0; r < 15; r++) begin
      jcfg = int'($urandom_range(0, 18));
      for (int k = 0; k < FILT_LEN; k++) jf[k] = DATA_W'($urandom);
      for (int i = 0; i < IFMAP_MAX; i++) jx[i] = DATA_W'($urandom);
      jgap = int'($urandom_range(0, 50));
      jhold = int'($urandom_range(0, 40));
      jhold_at = 0;
      jhold_len = 0;
      jabort_at = 0;
      jkeep = 0;
      jstart_in_done = 0;
      w = (jcfg > IFMAP_MAX) ? IFMAP_MAX : jcfg;
      run_job();
      compare_job($sformatf("rand%0d", r), (w >= FILT_LEN) ? (w - FILT_LEN + 1) * FILT_LEN : 0, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
